ascii_field2bin: RTL and testbench

ASCII_FIELD2BIN -- requirements
Module: ascii_field2bin

---
 rtl/nmea_pkg.sv | 26 ++
 rtl/ascii_digit_decode.sv | 21 ++
 rtl/ascii_field2bin.sv | 175 +++++++++++++++++
 tb/tb_ascii_field2bin.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nmea_pkg.sv
// Shared NMEA character constants and the field-parser state type.
// Used by ascii_digit_decode and ascii_field2bin.
package nmea_pkg;

    // ASCII codes used when parsing NMEA fields.
    localparam logic [7:0] ZERO   = 8'h30;
    localparam logic [7:0] NINE   = 8'h39;
    localparam logic [7:0] COMMA  = 8'h2C;
    localparam logic [7:0] STAR   = 8'h2A;
    localparam logic [7:0] CR     = 8'h0D;
    localparam logic [7:0] MINUS  = 8'h2D;
    localparam logic [7:0] DOLLAR = 8'h24;

    // EMPTY: no digits yet, ACCUM: at least one digit, BAD: error latched until a terminator.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ACCUM = 2'd1,
        ST_BAD   = 2'd2
    } field_state_t;

    // True for the characters '0'..'9'.
    function automatic logic is_dec_digit(input logic [7:0] ch);
        return (ch >= ZERO) && (ch <= NINE);
    endfunction

endpackage

// File: rtl/ascii_digit_decode.sv
// Combinational character classifier: the binary value of a decimal digit,
// plus flags telling whether the character is a digit or a field terminator.
module ascii_digit_decode
    import nmea_pkg::*;
#(
    parameter logic [7:0] DELIM = COMMA
) (
    input  logic [7:0] ch,
    output logic [3:0] value,
    output logic       is_digit,
    output logic       is_term
);

    // Classify one character; digit value is forced to 0 for non-digits.
    always_comb begin
        is_digit = is_dec_digit(ch);
        is_term  = (ch == DELIM) || (ch == STAR) || (ch == CR);
        value    = is_digit ? ch[3:0] : 4'd0;
    end

endmodule

// File: rtl/ascii_field2bin.sv
// ASCII decimal field to binary converter for NMEA-style character streams.
// Digits are accumulated in Horner form (acc*10 + digit); a terminator
// (DELIM, '*' or CR) reports the field with a one-cycle dout_valid strobe.
// Optional build macro: ASCII_FIELD_SIGN_EN adds a leading '-' sign and a
// two's complement dout one bit wider than the unsigned build.
module ascii_field2bin
    import nmea_pkg::*;
#(
    parameter int         MAX_DIGITS = 6,
    parameter logic [7:0] DELIM      = COMMA,
    localparam int        ACC_W      = $clog2(10**MAX_DIGITS),
`ifdef ASCII_FIELD_SIGN_EN
    localparam int        DOUT_W     = ACC_W + 1,
`else
    localparam int        DOUT_W     = ACC_W,
`endif
    localparam int        CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        ascii_in,
    input  logic              din_valid,
    input  logic              abort,
    output logic [DOUT_W-1:0] dout,
    output logic              dout_valid,
    output logic [CNT_W-1:0]  digit_cnt,
    output logic              err
);

    field_state_t      state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DOUT_W-1:0] dout_d;
    logic [CNT_W-1:0]  digit_cnt_d;
    logic              err_d;
    logic              dout_valid_d;

    logic [3:0]        dig_val;
    logic              is_digit;
    logic              is_term;
    logic              full;
    logic              sign_ok;
    logic              lone_minus;
    logic [DOUT_W-1:0] field_value;

`ifdef ASCII_FIELD_SIGN_EN
    logic              neg_q, neg_d;
`endif

    ascii_digit_decode #(
        .DELIM (DELIM)
    ) u_decode (
        .ch       (ascii_in),
        .value    (dig_val),
        .is_digit (is_digit),
        .is_term  (is_term)
    );

    // Field value, sign acceptance and lone-sign detection for the current build.
    always_comb begin
        full = (cnt_q == CNT_W'(MAX_DIGITS));
`ifdef ASCII_FIELD_SIGN_EN
        // A sign is only legal as the very first character of a field.
        sign_ok     = (ascii_in == MINUS) && (state_q == ST_EMPTY) && !neg_q;
        lone_minus  = neg_q && (state_q == ST_EMPTY);
        field_value = neg_q ? (DOUT_W'(0) - {1'b0, acc_q}) : {1'b0, acc_q};
`else
        sign_ok     = 1'b0;
        lone_minus  = 1'b0;
        field_value = acc_q;
`endif
    end

    // Next-state, accumulator and report logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned, which would infer a latch.
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        dout_d       = dout;
        digit_cnt_d  = digit_cnt;
        err_d        = err;
        dout_valid_d = 1'b0;
`ifdef ASCII_FIELD_SIGN_EN
        neg_d        = neg_q;
`endif

        if (abort) begin
            // Discard the field silently; abort wins over a simultaneous character.
            state_d = ST_EMPTY;
            acc_d   = '0;
            cnt_d   = '0;
`ifdef ASCII_FIELD_SIGN_EN
            neg_d   = 1'b0;
`endif
        end else if (din_valid) begin
            if (is_term) begin
                // Report the field and start a fresh one on the same edge.
                dout_valid_d = 1'b1;
                dout_d       = field_value;
                digit_cnt_d  = cnt_q;
                err_d        = (state_q == ST_BAD) || lone_minus;
                state_d      = ST_EMPTY;
                acc_d        = '0;
                cnt_d        = '0;
`ifdef ASCII_FIELD_SIGN_EN
                neg_d        = 1'b0;
`endif
            end else begin
                unique case (state_q)
                    ST_EMPTY, ST_ACCUM: begin
                        if (is_digit) begin
                            if (full) begin
                                // One digit too many: freeze the accumulator and flag the field.
                                state_d = ST_BAD;
                            end else begin
                                // Exact: with fewer than MAX_DIGITS digits, acc*10+9 < 10**MAX_DIGITS.
                                acc_d   = (acc_q * ACC_W'(10)) + ACC_W'(dig_val);
                                cnt_d   = cnt_q + CNT_W'(1);
                                state_d = ST_ACCUM;
                            end
                        end else if (sign_ok) begin
`ifdef ASCII_FIELD_SIGN_EN
                            neg_d = 1'b1;
`endif
                        end else begin
                            state_d = ST_BAD;
                        end
                    end
                    ST_BAD: begin
                        // Everything but a terminator is ignored once the field is bad.
                        state_d = ST_BAD;
                    end
                    default: begin
                        state_d = ST_EMPTY;
                    end
                endcase
            end
        end
    end

    // Parser state, accumulator and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            acc_q      <= '0;
            cnt_q      <= '0;
            dout       <= '0;
            digit_cnt  <= '0;
            err        <= 1'b0;
            dout_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            dout       <= dout_d;
            digit_cnt  <= digit_cnt_d;
            err        <= err_d;
            dout_valid <= dout_valid_d;
        end
    end

`ifdef ASCII_FIELD_SIGN_EN
    // Negative-sign flag for the field in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end
`endif

endmodule

// File: tb/tb_ascii_field2bin.sv
// Self-checking bench for ascii_field2bin: a table of directed fields, hand
// sequences for abort and mid-field reset, and random fields scored against
// a plain-integer model of the field rules. A monitor checks every strobe
// (cycle, value, count, error) and that outputs hold between strobes.
module tb_ascii_field2bin;

    localparam int MAXD  = 6;
    localparam int ACC_W = $clog2(10**MAXD);
`ifdef ASCII_FIELD_SIGN_EN
    localparam int DOUT_W       = ACC_W + 1;
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam int DOUT_W       = ACC_W;
    localparam bit SIGNED_BUILD = 1'b0;
`endif
    localparam int CNT_W = $clog2(MAXD + 1);

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic [7:0]        ascii_in  = 8'h00;
    logic              din_valid = 1'b0;
    logic              abort     = 1'b0;
    logic [DOUT_W-1:0] dout;
    logic              dout_valid;
    logic [CNT_W-1:0]  digit_cnt;
    logic              err;

    ascii_field2bin #(
        .MAX_DIGITS (MAXD),
        .DELIM      (8'h2C)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ascii_in   (ascii_in),
        .din_valid  (din_valid),
        .abort      (abort),
        .dout       (dout),
        .dout_valid (dout_valid),
        .digit_cnt  (digit_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;
        int cnt;
        bit err;
        int cyc;
    } exp_t;

    typedef struct {
        string txt;
        int    gap;
        int    d;
        int    cnt;
        bit    err;
    } vec_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    logic [DOUT_W-1:0] last_d = '0;
    logic [CNT_W-1:0]  last_c = '0;
    logic              last_e = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, got, got, want, want, cyc);
        end
    endtask

    // Reference: value of the digits taken before the first error, digit count, error flag.
    function automatic exp_t model(input byte body[$]);
        exp_t   e;
        longint val = 0;
        int     n   = 0;
        bit     bad = 1'b0;
        bit     neg = 1'b0;
        byte    c;
        foreach (body[i]) begin
            c = body[i];
            if (bad) continue;
            if (c >= 8'h30 && c <= 8'h39) begin
                if (n == MAXD) bad = 1'b1;
                else begin
                    val = val * 10 + longint'(c - 8'h30);
                    n++;
                end
            end else if (SIGNED_BUILD && c == 8'h2D && n == 0 && !neg) begin
                neg = 1'b1;
            end else begin
                bad = 1'b1;
            end
        end
        if (neg && n == 0) bad = 1'b1;
        e.d   = neg ? -int'(val) : int'(val);
        e.cnt = n;
        e.err = bad;
        e.cyc = 0;
        return e;
    endfunction

    function automatic void str2q(input string s, output byte q[$]);
        q = {};
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endfunction

    // Drive characters back-to-back or with idle gaps; the last one is the terminator if term=1.
    task automatic send(input byte chars[$], input int gap, input bit term, input exp_t e);
        exp_t ee;
        ee = e;
        foreach (chars[i]) begin
            ascii_in  = chars[i];
            din_valid = 1'b1;
            if (term && i == chars.size() - 1) begin
                ee.cyc = cyc + 1;
                exp_q.push_back(ee);
            end
            @(posedge clk);
            #1;
            din_valid = 1'b0;
            ascii_in  = 8'($urandom_range(0, 255));
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe scoreboard and hold checks, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t              e;
        logic [DOUT_W-1:0] want_d;
        if (rst) begin
            last_d = '0;
            last_c = '0;
            last_e = 1'b0;
        end else if (dout_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 64'(dout_valid), 64'(0));
            end else begin
                e      = exp_q.pop_front();
                want_d = DOUT_W'(e.d);
                check("strobe_cycle", 64'(cyc), 64'(e.cyc));
                check("dout", 64'(dout), 64'(want_d));
                check("digit_cnt", 64'(digit_cnt), 64'(e.cnt));
                check("err", 64'(err), 64'(e.err));
            end
            last_d = dout;
            last_c = digit_cnt;
            last_e = err;
        end else begin
            check("hold_dout", 64'(dout), 64'(last_d));
            check("hold_cnt", 64'(digit_cnt), 64'(last_c));
            check("hold_err", 64'(err), 64'(last_e));
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        byte  q[$];
        byte  body[$];
        exp_t e;
        byte  terms[3]  = '{8'h2C, 8'h2A, 8'h0D};
        byte  others[8] = '{8'h78, 8'h41, 8'h2D, 8'h2E, 8'h24, 8'h20, 8'h2F, 8'h3A};

        vecs.push_back('{"123456,",   0, 123456, 6, 1'b0});
        vecs.push_back('{"1234567,",  0, 123456, 6, 1'b1});
        vecs.push_back('{",",         0, 0,      0, 1'b0});
        vecs.push_back('{",",         1, 0,      0, 1'b0});
        vecs.push_back('{"12a4*",     3, 12,     2, 1'b1});
        vecs.push_back('{"07\015",    0, 7,      2, 1'b0});
        vecs.push_back('{"-42,",      0, SIGNED_BUILD ? -42 : 0, SIGNED_BUILD ? 2 : 0, !SIGNED_BUILD});
        vecs.push_back('{"4-2,",      1, 4,      1, 1'b1});
        vecs.push_back('{"-,",        0, 0,      0, 1'b1});
        vecs.push_back('{"999999*",   1, 999999, 6, 1'b0});
        vecs.push_back('{"0,",        0, 0,      1, 1'b0});
        vecs.push_back('{"a12,",      2, 0,      0, 1'b1});
        vecs.push_back('{"000042\015",0, 42,     6, 1'b0});

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_dout", 64'(dout), 64'(0));
        check("rst_cnt", 64'(digit_cnt), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_valid", 64'(dout_valid), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // Directed table.
        foreach (vecs[i]) begin
            str2q(vecs[i].txt, q);
            e.d   = vecs[i].d;
            e.cnt = vecs[i].cnt;
            e.err = vecs[i].err;
            e.cyc = 0;
            send(q, vecs[i].gap, 1'b1, e);
        end

        // Abort with a simultaneous terminator discards "98" with no strobe.
        str2q("98", q);
        send(q, 0, 1'b0, e);
        ascii_in  = 8'h2C;
        din_valid = 1'b1;
        abort     = 1'b1;
        @(posedge clk);
        #1;
        abort     = 1'b0;
        din_valid = 1'b0;
        str2q("5,", q);
        e = '{5, 1, 1'b0, 0};
        send(q, 2, 1'b1, e);

        // Reset mid-field: outputs clear, no strobe, next field starts fresh.
        str2q("98", q);
        send(q, 1, 1'b0, e);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_dout", 64'(dout), 64'(0));
        check("midrst_cnt", 64'(digit_cnt), 64'(0));
        check("midrst_err", 64'(err), 64'(0));
        check("midrst_valid", 64'(dout_valid), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        str2q("3,", q);
        e = '{3, 1, 1'b0, 0};
        send(q, 0, 1'b1, e);

        // Random fields against the model.
        for (int f = 0; f < 80; f++) begin
            int len;
            body = {};
            len  = $urandom_range(0, 8);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 19) < 16) body.push_back(byte'(8'h30 + $urandom_range(0, 9)));
                else body.push_back(others[$urandom_range(0, 7)]);
            end
            e = model(body);
            body.push_back(terms[$urandom_range(0, 2)]);
            send(body, $urandom_range(0, 2), 1'b1, e);
        end

        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("pending_strobes", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
